hqm_rcfwl_gclk_psocsync_ctrl: RTL and testbench

Controller that generates and sequences the periodic PSoC sync pulse driven into the repeater-based sync distribution tree on the free-running post-clock. It handles a 4-phase enable/acknowledge handshake with the requester and emits single-cycle sync pulses at a programmable period. It tracks pulses in flight through the `NUM_OF_RPTRS`-deep repeater chain, so it predicts leaf arrival and never drops acknowledge while a pulse is still propagating.

---
 rtl/hqm_rcfwl_gclk_psocsync_ctrl_if.sv | 24 ++
 rtl/hqm_rcfwl_gclk_psocsync_ctrl.sv | 140 ++++++++++++++
 tb/tb_hqm_rcfwl_gclk_psocsync_ctrl.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/hqm_rcfwl_gclk_psocsync_ctrl_if.sv
// Requester <-> PSoC sync controller bundle: enable/ack handshake, period
// configuration and the sync pulse / status outputs.
interface hqm_rcfwl_gclk_psocsync_ctrl_if #(
  parameter int unsigned PERIOD_W = 8,
  parameter int unsigned CNT_W    = 16
);
  logic                sync_en;
  logic [PERIOD_W-1:0] period_cfg;
  logic                sync_pulse;
  logic                sync_arrive;
  logic                sync_en_ack;
  logic                busy;
  logic [CNT_W-1:0]    pulse_cnt;

  modport master (
    output sync_en, period_cfg,
    input  sync_pulse, sync_arrive, sync_en_ack, busy, pulse_cnt
  );

  modport slave (
    input  sync_en, period_cfg,
    output sync_pulse, sync_arrive, sync_en_ack, busy, pulse_cnt
  );
endinterface

// File: rtl/hqm_rcfwl_gclk_psocsync_ctrl.sv
// PSoC sync pulse controller: 4-phase enable/ack handshake, periodic
// single-cycle sync pulses, and a shadow of the repeater chain so the
// leaf arrival is predicted and ack is held until every pulse has landed.
module hqm_rcfwl_gclk_psocsync_ctrl #(
  parameter int unsigned NUM_OF_RPTRS = 1,
  parameter int unsigned PERIOD_W     = 8,
  parameter int unsigned CNT_W        = 16
) (
  input logic                            adop_postclk_free,
  input logic                            rst,
  hqm_rcfwl_gclk_psocsync_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARM,
    ST_RUN,
    ST_DRAIN
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [PERIOD_W-1:0] r_peff;
  logic [PERIOD_W-1:0] w_peff;
  logic [PERIOD_W-1:0] r_cnt;
  logic [PERIOD_W-1:0] w_cnt_nxt;
  logic                r_pulse;
  logic                w_pulse_nxt;
  logic                r_ack;
  logic                w_ack_nxt;
  logic                r_busy;
  logic [CNT_W-1:0]    r_pcnt;
  logic [CNT_W-1:0]    w_pcnt_nxt;
  logic                w_trk_empty;

  // Effective period: sampled (and clamped to >= 2) only while in ARM.
  always_comb begin
    w_peff = r_peff;
    if (r_state == ST_ARM) begin
      w_peff = (bus.period_cfg < PERIOD_W'(2)) ? PERIOD_W'(2) : bus.period_cfg;
    end
  end

  // Next-state, pulse scheduling, handshake and pulse counter.
  // The pulse is registered, so the decision for cycle n+1 is made in cycle n
  // from the down-counter; ARM leaves the counter at 0 so RUN opens with a pulse.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_pulse_nxt = 1'b0;
    w_ack_nxt   = r_ack;
    w_pcnt_nxt  = r_pcnt;
    case (r_state)
      ST_IDLE: begin
        if (bus.sync_en && !r_ack) begin
          w_state_nxt = ST_ARM;
          w_cnt_nxt   = '0;
          w_pcnt_nxt  = '0;
        end
      end
      ST_ARM, ST_RUN: begin
        if (bus.sync_en) begin
          w_state_nxt = ST_RUN;
          w_ack_nxt   = 1'b1;
          if (r_cnt == '0) begin
            w_pulse_nxt = 1'b1;
            w_cnt_nxt   = w_peff - PERIOD_W'(1);
            w_pcnt_nxt  = r_pcnt + CNT_W'(1);
          end else begin
            w_cnt_nxt   = r_cnt - PERIOD_W'(1);
          end
        end else begin
          w_state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (w_trk_empty) begin
          w_state_nxt = ST_IDLE;
          w_ack_nxt   = 1'b0;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge adop_postclk_free) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_peff  <= PERIOD_W'(2);
      r_cnt   <= '0;
      r_pulse <= 1'b0;
      r_ack   <= 1'b0;
      r_busy  <= 1'b0;
      r_pcnt  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_peff  <= w_peff;
      r_cnt   <= w_cnt_nxt;
      r_pulse <= w_pulse_nxt;
      r_ack   <= w_ack_nxt;
      r_busy  <= (w_state_nxt != ST_IDLE);
      r_pcnt  <= w_pcnt_nxt;
    end
  end

  // In-flight tracker. A pulse sitting in the last stage is arriving this
  // cycle, so "empty" means nothing upstream of that stage (including the
  // pulse register) is still set.
  if (NUM_OF_RPTRS == 0) begin : g_trk_none
    assign w_trk_empty     = 1'b1;
    assign bus.sync_arrive = r_pulse;
  end else if (NUM_OF_RPTRS == 1) begin : g_trk_one
    logic r_trk;
    // Single repeater stage shadow.
    always_ff @(posedge adop_postclk_free) begin
      if (rst) r_trk <= 1'b0;
      else     r_trk <= r_pulse;
    end
    assign w_trk_empty     = !r_pulse;
    assign bus.sync_arrive = r_trk;
  end else begin : g_trk_multi
    logic [NUM_OF_RPTRS-1:0] r_trk;
    // Repeater chain shadow shift register.
    always_ff @(posedge adop_postclk_free) begin
      if (rst) r_trk <= '0;
      else     r_trk <= {r_trk[NUM_OF_RPTRS-2:0], r_pulse};
    end
    assign w_trk_empty     = !r_pulse && (r_trk[NUM_OF_RPTRS-2:0] == '0);
    assign bus.sync_arrive = r_trk[NUM_OF_RPTRS-1];
  end

  assign bus.sync_pulse  = r_pulse;
  assign bus.sync_en_ack = r_ack;
  assign bus.busy        = r_busy;
  assign bus.pulse_cnt   = r_pcnt;

endmodule

// File: tb/tb_hqm_rcfwl_gclk_psocsync_ctrl.sv
// Directed bench for the PSoC sync controller: DUT A (2 repeaters),
// DUT B (0 repeaters, shares A's inputs), DUT C (3 repeaters, 4-bit counter).
module tb_hqm_rcfwl_gclk_psocsync_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_ab;
  logic       rst_c;
  logic       en_a;
  logic [7:0] cfg_a;
  logic       en_c;
  logic [7:0] cfg_c;
  int         cyc;
  int         n_checks;
  int         n_errors;

  hqm_rcfwl_gclk_psocsync_ctrl_if #(.PERIOD_W(8), .CNT_W(16)) if_a ();
  hqm_rcfwl_gclk_psocsync_ctrl_if #(.PERIOD_W(8), .CNT_W(16)) if_b ();
  hqm_rcfwl_gclk_psocsync_ctrl_if #(.PERIOD_W(8), .CNT_W(4))  if_c ();

  assign if_a.sync_en    = en_a;
  assign if_a.period_cfg = cfg_a;
  assign if_b.sync_en    = en_a;
  assign if_b.period_cfg = cfg_a;
  assign if_c.sync_en    = en_c;
  assign if_c.period_cfg = cfg_c;

  hqm_rcfwl_gclk_psocsync_ctrl #(.NUM_OF_RPTRS(2), .PERIOD_W(8), .CNT_W(16)) u_dut_a (
    .adop_postclk_free (clk),
    .rst               (rst_ab),
    .bus               (if_a)
  );

  hqm_rcfwl_gclk_psocsync_ctrl #(.NUM_OF_RPTRS(0), .PERIOD_W(8), .CNT_W(16)) u_dut_b (
    .adop_postclk_free (clk),
    .rst               (rst_ab),
    .bus               (if_b)
  );

  hqm_rcfwl_gclk_psocsync_ctrl #(.NUM_OF_RPTRS(3), .PERIOD_W(8), .CNT_W(4)) u_dut_c (
    .adop_postclk_free (clk),
    .rst               (rst_c),
    .bus               (if_c)
  );

  // Advance to 1 time unit after the next rising edge; cyc names the cycle we are in.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_errors++;
      $error("FAIL %s cycle %0d observed %0d expected %0d", tag, cyc, obs, expv);
    end
  endtask

  // One request on DUT A/B: sync_en raised in the current cycle (offset 0),
  // lowered in cycle offset stop_k. period_cfg is changed mid-run to show it is ignored.
  // Expected: pulses at offsets 2 + j*peff up to stop_k, arrival 2 later on A,
  // same cycle on B; IDLE at max(stop_k+2, last_pulse+3).
  task automatic run_a(input logic [7:0] cfg, input int peff, input int stop_k);
    int last_p;
    int idle_o;
    int pc;
    logic ep;
    logic ea;
    last_p = -1;
    for (int o = 2; o <= stop_k; o += peff) last_p = o;
    if (last_p < 0)                   idle_o = stop_k + 2;
    else if (stop_k + 2 > last_p + 3) idle_o = stop_k + 2;
    else                              idle_o = last_p + 3;
    pc    = 0;
    en_a  = 1'b1;
    cfg_a = cfg;
    for (int o = 1; o <= idle_o + 2; o++) begin
      step();
      if (o == stop_k) en_a = 1'b0;
      if (o == 3)      cfg_a = 8'd3;
      ep = (o >= 2) && (o <= stop_k) && ((o - 2) % peff == 0);
      ea = (o >= 4) && (o - 2 <= stop_k) && ((o - 4) % peff == 0);
      if (ep) pc++;
      chk("a_pulse",  {31'd0, if_a.sync_pulse},  {31'd0, ep});
      chk("a_arrive", {31'd0, if_a.sync_arrive}, {31'd0, ea});
      chk("a_ack",    {31'd0, if_a.sync_en_ack}, {31'd0, (o >= 2) && (o < idle_o) && (last_p >= 0)});
      chk("a_busy",   {31'd0, if_a.busy},        {31'd0, (o < idle_o)});
      chk("a_pcnt",   {16'd0, if_a.pulse_cnt},   pc);
      chk("b_pulse",  {31'd0, if_b.sync_pulse},  {31'd0, ep});
      chk("b_arrive", {31'd0, if_b.sync_arrive}, {31'd0, ep});
    end
  endtask

  initial begin
    logic ep_c;
    logic ea_c;
    int   pc_c;
    cyc      = 0;
    n_checks = 0;
    n_errors = 0;
    rst_ab   = 1'b1;
    rst_c    = 1'b1;
    en_a     = 1'b0;
    cfg_a    = 8'd4;
    en_c     = 1'b0;
    cfg_c    = 8'd2;
    repeat (3) step();

    // Reset state.
    chk("rst_a_pulse",  {31'd0, if_a.sync_pulse},  32'd0);
    chk("rst_a_arrive", {31'd0, if_a.sync_arrive}, 32'd0);
    chk("rst_a_ack",    {31'd0, if_a.sync_en_ack}, 32'd0);
    chk("rst_a_busy",   {31'd0, if_a.busy},        32'd0);
    chk("rst_a_pcnt",   {16'd0, if_a.pulse_cnt},   32'd0);
    chk("rst_c_busy",   {31'd0, if_c.busy},        32'd0);
    chk("rst_c_pcnt",   {28'd0, if_c.pulse_cnt},   32'd0);
    rst_ab = 1'b0;
    rst_c  = 1'b0;
    while (cyc < 10) step();

    // Basic run: raise at 10, pulses 12/16/20, arrivals 14/18/22, drop in 22.
    run_a(8'd4, 4, 12);
    chk("basic_pcnt", {16'd0, if_a.pulse_cnt}, 32'd3);

    // Stop with pulse in flight: raise at 30, pulses 32/36, drop in 37,
    // arrival at 38 during DRAIN, IDLE at 39.
    while (cyc < 30) step();
    run_a(8'd4, 4, 7);
    chk("stop_pcnt", {16'd0, if_a.pulse_cnt}, 32'd2);

    // Minimum period clamp.
    run_a(8'd0, 2, 10);
    chk("clamp0_pcnt", {16'd0, if_a.pulse_cnt}, 32'd5);
    run_a(8'd1, 2, 9);
    chk("clamp1_pcnt", {16'd0, if_a.pulse_cnt}, 32'd4);

    // Maximum period.
    run_a(8'd255, 255, 258);
    chk("p255_pcnt", {16'd0, if_a.pulse_cnt}, 32'd2);

    // Abort in ARM: one-cycle request, no pulse, ack never rises.
    run_a(8'd4, 4, 1);
    chk("abort_pcnt", {16'd0, if_a.pulse_cnt}, 32'd0);

    // DUT C: P=2, 4-bit counter wrap, then reset one cycle after pulse 17.
    en_c  = 1'b1;
    cfg_c = 8'd2;
    for (int o = 1; o <= 35; o++) begin
      step();
      if (o == 35) begin
        rst_c = 1'b1;
        en_c  = 1'b0;
      end
      ep_c = (o >= 2) && (o % 2 == 0);
      ea_c = (o >= 5) && (o % 2 == 1);
      pc_c = (o / 2) % 16;
      chk("c_pulse",  {31'd0, if_c.sync_pulse},  {31'd0, ep_c});
      chk("c_arrive", {31'd0, if_c.sync_arrive}, {31'd0, ea_c});
      chk("c_pcnt",   {28'd0, if_c.pulse_cnt},   pc_c);
      if (o == 30) chk("wrap_p15", {28'd0, if_c.pulse_cnt}, 32'd15);
      if (o == 32) chk("wrap_p16", {28'd0, if_c.pulse_cnt}, 32'd0);
      if (o == 34) chk("wrap_p17", {28'd0, if_c.pulse_cnt}, 32'd1);
    end
    step();
    rst_c = 1'b0;
    for (int o = 0; o < 6; o++) begin
      chk("rst_mid_pulse",  {31'd0, if_c.sync_pulse},  32'd0);
      chk("rst_mid_arrive", {31'd0, if_c.sync_arrive}, 32'd0);
      chk("rst_mid_ack",    {31'd0, if_c.sync_en_ack}, 32'd0);
      chk("rst_mid_busy",   {31'd0, if_c.busy},        32'd0);
      chk("rst_mid_pcnt",   {28'd0, if_c.pulse_cnt},   32'd0);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
